// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: sequencer state and per-stage freeze/flush record.
package pipe_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 4;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipeStateT;

    // One freeze (load inhibit) or flush (synchronous clear) bit per pipeline register.
    typedef struct packed {
        logic freezePC;
        logic freezeIFID;
        logic freezeIDEX;
        logic freezeEXMEM;
        logic freezeMEMWB;
        logic flushIFID;
        logic flushIDEX;
    } pipeCtrlT;

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard comparator between the ID-stage sources and the EX/MEM destinations.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  fwdEn,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  twoSrc,
    input  logic                  src1Valid,
    input  logic [REG_ADDR_W-1:0] exDest,
    input  logic                  exWbEn,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] memDest,
    input  logic                  memWbEn,
    output logic                  hz
);

    logic exHit1, exHit2, memHit1, memHit2;

    // With forwarding only a load in EX cannot be bypassed; without it every pending write stalls.
    always_comb begin
        exHit1  = src1Valid & exWbEn  & (src1 == exDest);
        exHit2  = twoSrc    & exWbEn  & (src2 == exDest);
        memHit1 = src1Valid & memWbEn & (src1 == memDest);
        memHit2 = twoSrc    & memWbEn & (src2 == memDest);
        if (fwdEn) begin
            hz = (exHit1 | exHit2) & exMemRead;
        end else begin
            hz = exHit1 | exHit2 | memHit1 | memHit2;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: freeze/flush generation, SRAM wait tracking, stall statistics.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fwdEn,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  twoSrc,
    input  logic                  src1Valid,
    input  logic [REG_ADDR_W-1:0] exDest,
    input  logic                  exWbEn,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] memDest,
    input  logic                  memWbEn,
    input  logic                  memReq,
    input  logic                  sramReady,
    input  logic                  branchTaken,
    output logic                  freezePC,
    output logic                  freezeIFID,
    output logic                  freezeIDEX,
    output logic                  freezeEXMEM,
    output logic                  freezeMEMWB,
    output logic                  flushIFID,
    output logic                  flushIDEX,
    output logic [CNT_W-1:0]      stallCount,
    output logic                  waitTimeout
);

    localparam int unsigned       WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    pipeStateT         state, stateNext;
    pipeCtrlT          ctrl;
    logic              hz, memStall, anyFreeze;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic [CNT_W-1:0]  stallCnt;
    logic              timeoutFlag;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) uDetect (
        .fwdEn    (fwdEn),
        .src1     (src1),
        .src2     (src2),
        .twoSrc   (twoSrc),
        .src1Valid(src1Valid),
        .exDest   (exDest),
        .exWbEn   (exWbEn),
        .exMemRead(exMemRead),
        .memDest  (memDest),
        .memWbEn  (memWbEn),
        .hz       (hz)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and prioritised controls: memory stall > branch squash > hazard bubble.
    always_comb begin
        stateNext = state;
        memStall  = 1'b0;
        ctrl      = '0;
        case (state)
            RUN: begin
                if (memReq && !sramReady) begin
                    memStall  = 1'b1;
                    stateNext = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // memReq is held by the SRAM controller while frozen, so only completion matters.
                if (sramReady) begin
                    stateNext = RUN;
                end else begin
                    memStall = 1'b1;
                end
            end
            default: stateNext = RUN;
        endcase

        if (memStall) begin
            ctrl.freezePC    = 1'b1;
            ctrl.freezeIFID  = 1'b1;
            ctrl.freezeIDEX  = 1'b1;
            ctrl.freezeEXMEM = 1'b1;
            ctrl.freezeMEMWB = 1'b1;
        end else if (branchTaken) begin
            ctrl.flushIFID = 1'b1;
            ctrl.flushIDEX = 1'b1;
        end else if (hz) begin
            ctrl.freezePC   = 1'b1;
            ctrl.freezeIFID = 1'b1;
            ctrl.flushIDEX  = 1'b1;
        end

        anyFreeze = ctrl.freezePC | ctrl.freezeIFID | ctrl.freezeIDEX
                  | ctrl.freezeEXMEM | ctrl.freezeMEMWB;
        waitNext  = (waitCnt == WAIT_LIMIT) ? waitCnt : waitCnt + 1'b1;
    end

    // Wait-cycle counter and sticky timeout; counting restarts whenever the FSM is back in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt     <= '0;
            timeoutFlag <= 1'b0;
        end else if (state == MEM_WAIT && !sramReady) begin
            waitCnt <= waitNext;
            if (waitNext == WAIT_LIMIT) begin
                timeoutFlag <= 1'b1;
            end
        end else begin
            waitCnt <= '0;
        end
    end

    // Saturating count of cycles with any freeze asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (anyFreeze && stallCnt != '1) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign freezePC    = ctrl.freezePC;
    assign freezeIFID  = ctrl.freezeIFID;
    assign freezeIDEX  = ctrl.freezeIDEX;
    assign freezeEXMEM = ctrl.freezeEXMEM;
    assign freezeMEMWB = ctrl.freezeMEMWB;
    assign flushIFID   = ctrl.flushIFID;
    assign flushIDEX   = ctrl.flushIDEX;
    assign stallCount  = stallCnt;
    assign waitTimeout = timeoutFlag;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic.
module tb_hazard_ctrl;

    localparam int AW     = 4;
    localparam int CW     = 4;
    localparam int MAXW   = 8;
    localparam int CNTMAX = 15;

    typedef struct {
        bit          rst, fwdEn, twoSrc, src1Valid, exWbEn, exMemRead, memWbEn;
        bit          memReq, sramReady, branchTaken;
        bit [AW-1:0] src1, src2, exDest, memDest;
    } stimT;

    typedef struct {
        bit [6:0]    ctrl;   // {fPC,fIFID,fIDEX,fEXMEM,fMEMWB,flIFID,flIDEX}
        bit [CW-1:0] stalls;
        bit          timeout;
        string       tag;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fwdEn = 1'b0, twoSrc = 1'b0, src1Valid = 1'b0, exWbEn = 1'b0, exMemRead = 1'b0;
    logic memWbEn = 1'b0, memReq = 1'b0, sramReady = 1'b0, branchTaken = 1'b0;
    logic [AW-1:0] src1 = '0, src2 = '0, exDest = '0, memDest = '0;
    logic freezePC, freezeIFID, freezeIDEX, freezeEXMEM, freezeMEMWB, flushIFID, flushIDEX;
    logic [CW-1:0] stallCount;
    logic waitTimeout;

    int total = 0;
    int bad   = 0;
    expT scb[$];

    // Reference model: "waiting" means last cycle was a memory stall.
    bit mWaiting = 0;
    int mWaitCycles = 0;
    int mStalls = 0;
    bit mTimeout = 0;

    hazard_ctrl #(
        .REG_ADDR_W(AW),
        .CNT_W     (CW),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk(clk), .rst(rst), .fwdEn(fwdEn),
        .src1(src1), .src2(src2), .twoSrc(twoSrc), .src1Valid(src1Valid),
        .exDest(exDest), .exWbEn(exWbEn), .exMemRead(exMemRead),
        .memDest(memDest), .memWbEn(memWbEn),
        .memReq(memReq), .sramReady(sramReady), .branchTaken(branchTaken),
        .freezePC(freezePC), .freezeIFID(freezeIFID), .freezeIDEX(freezeIDEX),
        .freezeEXMEM(freezeEXMEM), .freezeMEMWB(freezeMEMWB),
        .flushIFID(flushIFID), .flushIDEX(flushIDEX),
        .stallCount(stallCount), .waitTimeout(waitTimeout)
    );

    always #5 clk = ~clk;

    function automatic stimT idle();
        stimT s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic bit refHazard(input stimT s);
        bit [AW-1:0] rd[2];
        bit          rv[2];
        bit [AW-1:0] wd[2];
        bit          wv[2];
        rd[0] = s.src1;   rv[0] = s.src1Valid;
        rd[1] = s.src2;   rv[1] = s.twoSrc;
        wd[0] = s.exDest;  wv[0] = s.exWbEn && (!s.fwdEn || s.exMemRead);
        wd[1] = s.memDest; wv[1] = s.memWbEn && !s.fwdEn;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (rv[i] && wv[j] && rd[i] == wd[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cyc(input stimT s, input string tag);
        expT e;
        bit  memStall;
        @(posedge clk);
        #1;
        rst = s.rst; fwdEn = s.fwdEn; twoSrc = s.twoSrc; src1Valid = s.src1Valid;
        exWbEn = s.exWbEn; exMemRead = s.exMemRead; memWbEn = s.memWbEn;
        memReq = s.memReq; sramReady = s.sramReady; branchTaken = s.branchTaken;
        src1 = s.src1; src2 = s.src2; exDest = s.exDest; memDest = s.memDest;
        if (s.rst) begin
            mWaiting = 0; mWaitCycles = 0; mStalls = 0; mTimeout = 0;
        end
        memStall = mWaiting ? !s.sramReady : (s.memReq && !s.sramReady);
        if (memStall)           e.ctrl = 7'b1111100;
        else if (s.branchTaken) e.ctrl = 7'b0000011;
        else if (refHazard(s))  e.ctrl = 7'b1100001;
        else                    e.ctrl = 7'b0000000;
        e.stalls  = CW'(mStalls);
        e.timeout = mTimeout;
        e.tag     = tag;
        scb.push_back(e);
        if (!s.rst) begin
            if (e.ctrl[6:2] != 0 && mStalls < CNTMAX) mStalls++;
            mWaitCycles = (mWaiting && !s.sramReady) ? mWaitCycles + 1 : 0;
            if (mWaitCycles >= MAXW) mTimeout = 1;
            mWaiting = memStall;
        end
    endtask

    // Monitor: every cycle the DUT presents a full control word; compare it mid-cycle.
    initial begin
        expT e;
        bit [6:0] got;
        forever begin
            @(negedge clk);
            if (scb.size() > 0) begin
                e = scb.pop_front();
                got = {freezePC, freezeIFID, freezeIDEX, freezeEXMEM, freezeMEMWB, flushIFID, flushIDEX};
                total++;
                if (got !== e.ctrl) begin
                    bad++;
                    $display("FAIL ctrl[%s] @%0t: got %b want %b", e.tag, $time, got, e.ctrl);
                end
                total++;
                if (stallCount !== e.stalls) begin
                    bad++;
                    $display("FAIL stallCount[%s] @%0t: got %0d want %0d", e.tag, $time, stallCount, e.stalls);
                end
                total++;
                if (waitTimeout !== e.timeout) begin
                    bad++;
                    $display("FAIL waitTimeout[%s] @%0t: got %b want %b", e.tag, $time, waitTimeout, e.timeout);
                end
            end
        end
    end

    initial begin
        stimT s;
        stimT r;
        bit   slow;

        r = idle(); r.rst = 1;
        cyc(r, "reset");
        cyc(r, "reset");

        // RAW without forwarding: EX hit, then MEM hit, then clear.
        s = idle(); s.src1 = 3; s.src1Valid = 1; s.exDest = 3; s.exWbEn = 1;
        cyc(s, "raw_ex");
        s.exDest = 5; s.memDest = 3; s.memWbEn = 1;
        cyc(s, "raw_mem");
        s.memWbEn = 0;
        cyc(s, "raw_clear");

        // Load-use with forwarding, then the same with a non-load producer.
        cyc(r, "reset");
        s = idle(); s.fwdEn = 1; s.exMemRead = 1; s.exWbEn = 1; s.exDest = 7; s.src2 = 7; s.twoSrc = 1;
        cyc(s, "load_use");
        s.exMemRead = 0; s.exDest = 2; s.memDest = 7; s.memWbEn = 1;
        cyc(s, "load_in_mem");
        s = idle(); s.fwdEn = 1; s.exWbEn = 1; s.exDest = 7; s.src2 = 7; s.twoSrc = 1;
        cyc(s, "alu_fwd");

        // Four-cycle SRAM wait.
        cyc(r, "reset");
        s = idle(); s.memReq = 1;
        for (int i = 0; i < 4; i++) cyc(s, "mem_wait4");
        s.sramReady = 1;
        cyc(s, "mem_done");
        s = idle();
        cyc(s, "mem_after");
        s.memReq = 1; s.sramReady = 1;
        cyc(s, "mem_fast");

        // Branch beats hazard; branch during wait is held off until sramReady.
        cyc(r, "reset");
        s = idle(); s.branchTaken = 1; s.src1 = 9; s.src1Valid = 1; s.exDest = 9; s.exWbEn = 1;
        cyc(s, "br_vs_hz");
        s = idle(); s.branchTaken = 1; s.memReq = 1;
        cyc(s, "br_wait_enter");
        cyc(s, "br_wait");
        s.sramReady = 1;
        cyc(s, "br_wait_done");

        // Timeout after MAX_WAIT wait cycles, sticky past exit.
        cyc(r, "reset");
        s = idle(); s.memReq = 1;
        for (int i = 0; i < 10; i++) cyc(s, "timeout_wait");
        s.sramReady = 1;
        cyc(s, "timeout_exit");
        s = idle();
        cyc(s, "timeout_hold");
        cyc(s, "timeout_hold");

        // Reset in the middle of a wait returns to RUN at once.
        cyc(r, "reset");
        s = idle(); s.memReq = 1;
        for (int i = 0; i < 5; i++) cyc(s, "pre_rst_wait");
        s.rst = 1;
        cyc(s, "rst_mid_wait");
        s = idle();
        cyc(s, "post_rst_run");

        // Stall counter saturation.
        cyc(r, "reset");
        s = idle(); s.memReq = 1;
        for (int i = 0; i < 20; i++) cyc(s, "sat_wait");
        s.sramReady = 1;
        cyc(s, "sat_exit");
        s = idle();
        cyc(s, "sat_hold");

        // Randomized traffic with occasional slow SRAM phases and resets.
        slow = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) slow = ($urandom_range(0, 2) == 0);
            s.rst         = ($urandom_range(0, 149) == 0);
            s.fwdEn       = $urandom_range(0, 1) == 1;
            s.twoSrc      = $urandom_range(0, 1) == 1;
            s.src1Valid   = $urandom_range(0, 3) != 0;
            s.exWbEn      = $urandom_range(0, 1) == 1;
            s.exMemRead   = $urandom_range(0, 1) == 1;
            s.memWbEn     = $urandom_range(0, 1) == 1;
            s.memReq      = $urandom_range(0, 2) == 0;
            s.sramReady   = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            s.branchTaken = $urandom_range(0, 5) == 0;
            s.src1        = AW'($urandom_range(0, 3));
            s.src2        = AW'($urandom_range(0, 3));
            s.exDest      = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
            s.memDest     = AW'($urandom_range(0, 3));
            cyc(s, "random");
        end

        for (int k = 0; k < 5 && scb.size() > 0; k++) @(posedge clk);
        if (scb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", scb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It generates the freeze (load-inhibit) and flush (synchronous clear) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three causes: RAW data hazards, taken branches, and multi-cycle SRAM accesses in the MEM stage. It also keeps a saturating stall counter and a sticky timeout flag for the memory-wait path.

## Interface
Parameters:
- REG_ADDR_W, 4, register-address width
- CNT_W, 16, stall-counter width
- MAX_WAIT, 255, longest legal SRAM wait in cycles before timeout

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- fwdEn  in  1  1 = forwarding unit present; only load-use hazards stall
- src1  in  REG_ADDR_W  Rn of instruction in ID
- src2  in  REG_ADDR_W  Rm/Rd-store source of instruction in ID
- twoSrc  in  1  ID instruction reads src2
- src1Valid  in  1  ID instruction reads src1
- exDest  in  REG_ADDR_W  destination in EX
- exWbEn  in  1  EX instruction writes back
- exMemRead  in  1  EX instruction is a load
- memDest  in  REG_ADDR_W  destination in MEM
- memWbEn  in  1  MEM instruction writes back
- memReq  in  1  MEM stage issues a read or write to the SRAM controller this cycle
- sramReady  in  1  SRAM controller access complete
- branchTaken  in  1  taken branch resolved in EX
- freezePC, freezeIFID, freezeIDEX, freezeEXMEM, freezeMEMWB  out  1 each  load inhibit per register
- flushIFID, flushIDEX  out  1 each  clear per register
- stallCount  out  CNT_W  cycles with any freeze asserted, saturating
- waitTimeout  out  1  sticky; set when an SRAM wait exceeds MAX_WAIT

## Operation
- FSM states are RUN and MEM_WAIT.
- RUN -> MEM_WAIT when memReq=1 and sramReady=0.
- MEM_WAIT -> RUN on the cycle sramReady=1.
- Data hazard `hz`:
  - fwdEn=0: (src1Valid & exWbEn & src1==exDest) | (twoSrc & exWbEn & src2==exDest) | the same two terms against memDest/memWbEn.
  - fwdEn=1: only the EX terms, each further qualified by exMemRead.
- Memory stall `ms` = (state==RUN & memReq & ~sramReady) | (state==MEM_WAIT & ~sramReady).
- Outputs, highest priority first:
  - ms=1: all five freezes=1; flushes=0. Branch and hazard are ignored, and stay pending in the frozen stages.
  - branchTaken=1: flushIFID=1, flushIDEX=1; no freezes. The branch overrides hz, because the hazarding instruction is squashed.
  - hz=1: freezePC=1, freezeIFID=1, flushIDEX=1 (bubble); EX/MEM and MEM/WB advance.
  - otherwise: all outputs 0.
- Wait counter:
  - Counts cycles spent in MEM_WAIT; cleared on entry to RUN.
  - If it reaches MAX_WAIT, waitTimeout sets and stays set until rst. The FSM keeps waiting; there is no forced exit.
- stallCount:
  - Increments on any clock edge where any freeze output is 1.
  - Saturates at 2^CNT_W-1.
- Register 0 is not special. Address comparisons are plain equality across REG_ADDR_W bits.

## Timing
- All freeze/flush outputs are combinational (Mealy) from the current state and inputs, so they are valid in the same cycle as the cause. No added latency.
- A memory stall begins in the cycle memReq rises with sramReady=0. It ends in the cycle sramReady=1: freezes drop combinationally, and the pipeline advances on that edge.
- memReq with sramReady=1 in the same cycle: no stall; the state stays RUN.
- The SRAM controller holds memReq stable while frozen. hazard_ctrl does not re-check memReq in MEM_WAIT.
- Load-use with fwdEn=1 costs exactly one bubble: on the next cycle the load is in MEM and the term clears.
- Reset (asynchronous, any cycle including mid-MEM_WAIT):
  - state=RUN, wait counter=0, stallCount=0, waitTimeout=0.
  - Outputs then follow the RUN equations on the current inputs.
- stallCount and waitTimeout update on the rising edge following the qualifying cycle.

## Structure
- Shared package pipe_pkg:
  - state enum {RUN, MEM_WAIT}
  - REG_ADDR_W default
  - the record of per-stage freeze/flush bits, shared with the pipeline top level
- Sub-module hazard_detect: purely combinational `hz` comparator. Reused by a future forwarding unit.
- Everything else (FSM, counters, priority mux) lives in hazard_ctrl.

## Test plan
- fwdEn=0; src1=3, src1Valid=1, exDest=3, exWbEn=1 -> freezePC=freezeIFID=flushIDEX=1, other outputs 0; next cycle with exDest=5 and memDest=3 still stalls; the following cycle clears. stallCount=2.
- fwdEn=1; exMemRead=1, exDest=7, src2=7, twoSrc=1 -> one-cycle bubble. Same case with exMemRead=0 -> no stall.
- memReq=1, sramReady=0 for 4 cycles, then 1 -> all freezes=1 for 4 cycles, 0 in the 5th. FSM RUN->MEM_WAIT->RUN. stallCount=4.
- branchTaken=1 together with hz=1 -> flushIFID=flushIDEX=1 and freezePC=0. branchTaken=1 during MEM_WAIT -> only freezes asserted; flush appears in the cycle sramReady=1.
- MAX_WAIT=8; sramReady held 0 for 10 cycles -> waitTimeout=1 from cycle 9 onward, held after exit. Reset asserted mid-wait -> state RUN, all counters 0 immediately.
- stallCount with CNT_W=4: 20 consecutive stall cycles -> stallCount=15 and holds.
